// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes and
// the datapath mux-select codes it drives.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Successor of DECODE; unknown opcodes either trap or retire as a NOP.
    function automatic state_t decode_next(input logic [5:0] opcode, input bit trap_on_illegal);
        case (opcode)
            OP_RTYPE:     return S_EXECUTE;
            OP_LW, OP_SW: return S_MEM_ADDR;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
            OP_ADDI:      return S_ADDI_EXEC;
            default:      return trap_on_illegal ? S_TRAP : S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, stalling on MemReady in the three memory states.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Exception,
    output logic [3:0] State
);

    state_t state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    assign State = state_q;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through the decode leaves a signal unassigned (no latches).
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        Exception   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // IR and PC load only on the cycle the instruction word arrives.
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_d = S_DECODE;
            end

            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                state_d = decode_next(Opcode, TRAP_ON_ILLEGAL);
            end

            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end

            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) state_d = S_MEM_WB;
            end

            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end

            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end

            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_R_WB;
            end

            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                state_d     = S_FETCH;
            end

            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                state_d  = S_FETCH;
            end

            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDI_WB;
            end

            S_ADDI_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end

            S_TRAP: Exception = 1'b1;

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: table-driven instruction walk
// plus hand sequences for async reset and illegal-opcode handling.
module tb_mips_multicycle_control;
    import mips_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [5:0] Opcode;
    logic       MemReady;

    logic       a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rdst, a_rw, a_srca, a_exc;
    logic [1:0] a_srcb, a_aluop, a_pcsrc;
    logic [3:0] a_state;
    logic       b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rdst, b_rw, b_srca, b_exc;
    logic [1:0] b_srcb, b_aluop, b_pcsrc;
    logic [3:0] b_state;

    mips_multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut_trap (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mr),
        .MemWrite(a_mw), .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
        .RegWrite(a_rw), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALUOp(a_aluop),
        .PCSource(a_pcsrc), .Exception(a_exc), .State(a_state)
    );

    mips_multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mr),
        .MemWrite(b_mw), .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
        .RegWrite(b_rw), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALUOp(b_aluop),
        .PCSource(b_pcsrc), .Exception(b_exc), .State(b_state)
    );

    always #5 Clock = ~Clock;

    // Output word order: pcw pcwc iord mr mw irw m2r rdst rw srca srcb aluop pcsrc exc
    logic [16:0] a_word, b_word;
    assign a_word = {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rdst, a_rw, a_srca,
                     a_srcb, a_aluop, a_pcsrc, a_exc};
    assign b_word = {b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rdst, b_rw, b_srca,
                     b_srcb, b_aluop, b_pcsrc, b_exc};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] ow(
        input logic pcw, input logic pcwc, input logic iord, input logic mr, input logic mw,
        input logic irw, input logic m2r, input logic rdst, input logic rw, input logic srca,
        input logic [1:0] srcb, input logic [1:0] aluop, input logic [1:0] pcsrc, input logic exc);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, exc};
    endfunction

    // Hand-written expected outputs per state (FETCH depends on MemReady).
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic rdy);
        case (st)
            4'd1:  return ow(rdy, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
            4'd2:  return ow(0,   0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
            4'd3:  return ow(0,   0, 0, 0, 0, 0,   0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            4'd4:  return ow(0,   0, 1, 1, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            4'd5:  return ow(0,   0, 0, 0, 0, 0,   1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            4'd6:  return ow(0,   0, 1, 0, 1, 0,   0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            4'd7:  return ow(0,   0, 0, 0, 0, 0,   0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
            4'd8:  return ow(0,   0, 0, 0, 0, 0,   0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            4'd9:  return ow(0,   1, 0, 0, 0, 0,   0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
            4'd10: return ow(1,   0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
            4'd11: return ow(0,   0, 0, 0, 0, 0,   0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            4'd12: return ow(0,   0, 0, 0, 0, 0,   0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            4'd15: return ow(0,   0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
            default: return '0;
        endcase
    endfunction

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st;
        vecs.push_back(v);
    endtask

    initial begin
        // R-type, MemReady=0 outside memory states must be ignored
        add(6'b000000, 1, 1); add(6'b000000, 0, 2); add(6'b000000, 0, 7); add(6'b000000, 0, 8);
        // lw with two MEM_READ wait cycles
        add(6'b100011, 1, 1); add(6'b100011, 1, 2); add(6'b100011, 1, 3);
        add(6'b100011, 0, 4); add(6'b100011, 0, 4); add(6'b100011, 1, 4); add(6'b100011, 1, 5);
        // sw with one MEM_WRITE wait cycle
        add(6'b101011, 1, 1); add(6'b101011, 0, 2); add(6'b101011, 1, 3);
        add(6'b101011, 0, 6); add(6'b101011, 1, 6);
        // beq, j, addi
        add(6'b000100, 1, 1); add(6'b000100, 1, 2); add(6'b000100, 1, 9);
        add(6'b000010, 1, 1); add(6'b000010, 1, 2); add(6'b000010, 1, 10);
        add(6'b001000, 1, 1); add(6'b001000, 1, 2); add(6'b001000, 1, 11); add(6'b001000, 1, 12);
        // FETCH stall for 3 cycles, then a jump
        add(6'b000010, 0, 1); add(6'b000010, 0, 1); add(6'b000010, 0, 1);
        add(6'b000010, 1, 1); add(6'b000010, 1, 2); add(6'b000010, 1, 10);

        Reset = 1'b0; MemReady = 1'b0; Opcode = 6'b000000;
        #2 Reset = 1'b1;
        @(negedge Clock); #1;
        check("reset state", {28'd0, a_state}, 32'd0);
        check("reset outs",  {15'd0, a_word}, 32'd0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge Clock);
            Opcode = vecs[i].op; MemReady = vecs[i].rdy;
            #1;
            check($sformatf("v%0d trap state", i), {28'd0, a_state}, {28'd0, vecs[i].st});
            check($sformatf("v%0d trap outs", i),  {15'd0, a_word},  {15'd0, exp_outs(vecs[i].st, vecs[i].rdy)});
            check($sformatf("v%0d nop state", i),  {28'd0, b_state}, {28'd0, vecs[i].st});
            check($sformatf("v%0d nop outs", i),   {15'd0, b_word},  {15'd0, exp_outs(vecs[i].st, vecs[i].rdy)});
        end

        // Async reset in the middle of EXECUTE
        @(negedge Clock); Opcode = 6'b000000; MemReady = 1'b1;
        @(negedge Clock);
        @(negedge Clock); #1;
        check("pre-reset execute", {28'd0, a_state}, 32'd7);
        #2 Reset = 1'b1;
        #1;
        check("async reset state", {28'd0, a_state}, 32'd0);
        check("async reset outs",  {15'd0, a_word}, 32'd0);
        @(negedge Clock); #1;
        check("reset held state", {28'd0, a_state}, 32'd0);
        Reset = 1'b0;
        @(negedge Clock); #1;
        check("post-reset fetch", {28'd0, a_state}, 32'd1);
        check("post-reset memread", {31'd0, a_mr}, 32'd1);

        // Illegal opcode: sticky trap vs. NOP retire
        Opcode = 6'b111111; MemReady = 1'b1;
        @(negedge Clock); #1;
        check("illegal decode trap", {28'd0, a_state}, 32'd2);
        check("illegal decode nop",  {28'd0, b_state}, 32'd2);
        @(negedge Clock); #1;
        check("trap entered", {28'd0, a_state}, 32'd15);
        check("nop to fetch", {28'd0, b_state}, 32'd1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clock); #1;
            check($sformatf("trap hold %0d state", i), {28'd0, a_state}, 32'd15);
            check($sformatf("trap hold %0d outs", i),  {15'd0, a_word},  {15'd0, exp_outs(4'd15, 1'b1)});
            check($sformatf("nop cycle %0d state", i), {28'd0, b_state}, (i % 2 == 1) ? 32'd2 : 32'd1);
            check($sformatf("nop cycle %0d exc", i),   {31'd0, b_exc},   32'd0);
        end
        #2 Reset = 1'b1;
        #1;
        check("trap cleared state", {28'd0, a_state}, 32'd0);
        check("trap cleared exc",   {31'd0, a_exc},   32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multicycle MIPS main control FSM. It sequences instruction fetch, decode, execute, memory access and register-file writeback. It sits beside the register file and ALU, and drives the regfile RegWrite strobe plus all datapath mux selects. A MemReady handshake stalls it on slow memory.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters TRAP (sticky); 0: it is treated as a NOP and the FSM returns to FETCH.

Ports:
Clock  in  1  system clock; all state changes on the rising edge
Reset  in  1  asynchronous, active-high; forces state IDLE
Opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH
MemReady  in  1  memory completes the current MemRead/MemWrite this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  regfile WriteData select: 0 = ALUOut, 1 = MDR
RegDst  out  1  WriteAddr select: 0 = rt, 1 = rd
RegWrite  out  1  regfile write strobe
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
ALUOp  out  2  00 = add, 01 = sub, 10 = funct field
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
Exception  out  1  illegal opcode trapped
State  out  4  current state encoding (debug)

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=15. Encodings 13 and 14 are unused and go to IDLE.
- Reset, asserted at any time (including mid-instruction or during a stall), sends the state to IDLE immediately. In IDLE every output is 0 and State=0.
- First rising edge after Reset deasserts: IDLE -> FETCH.
- Outputs are Moore, decoded from the state. The only exceptions are IRWrite/PCWrite in FETCH, which are qualified by MemReady. Any output not listed below is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - anything else -> TRAP (or FETCH if TRAP_ON_ILLEGAL=0)
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Holds while MemReady=0; goes to MEM_WB on MemReady=1.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds while MemReady=0; goes to FETCH on MemReady=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- TRAP: Exception=1, all other outputs 0. Holds until Reset.
- Cycle counts with MemReady tied to 1, FETCH to FETCH: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle with MemReady=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Invariants:
  - RegWrite is high for exactly one cycle per register-writing instruction.
  - MemRead and MemWrite are never high together.
  - MemWrite is never high outside MEM_WRITE.
- MemReady is ignored outside the three memory states.

Decomposition:
- Package mips_pkg holds the state enum/encodings, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), and the ALUOp, ALUSrcB and PCSource encodings.
- No sub-module. Use one sequential state register process and one combinational next-state/output process.

Test Plan:
- Reset pulse mid-EXECUTE -> State=0 and all outputs 0 asynchronously; first edge after release gives State=1, MemRead=1.
- R-type (Opcode=000000), MemReady=1 -> states 1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8; ALUOp=10 in state 7.
- lw (100011) with MemReady low for 2 cycles in MEM_READ -> states 1,2,3,4,4,4,5,1; RegWrite with MemtoReg=1 in state 5 only.
- sw (101011), then beq (000100), then j (000010) -> MemWrite only in state 6; PCWriteCond=1 with PCSource=01 in state 9; PCWrite=1 with PCSource=10 in state 10.
- FETCH stall: MemReady=0 for 3 cycles -> IRWrite and PCWrite stay 0 until the MemReady=1 cycle, then both pulse for 1 cycle.
- Opcode=111111 -> State=15 and Exception=1, held for 10+ cycles until Reset. With TRAP_ON_ILLEGAL=0, the same opcode returns to FETCH after DECODE and Exception stays 0.
